aligned_acc_pipe: RTL



---
 rtl/aligned_acc_pipe.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/aligned_acc_pipe.sv
// Streaming exponent-aligning accumulator: S1 aligns each mantissa to its reference
// exponent, S2 adds it into a saturating group accumulator and emits on last.
module aligned_acc_pipe #(
   parameter int ACC_W = 32,
   parameter int IN_W  = 14,
   parameter int EXP_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic [EXP_W-1:0] in_exp,
   input  logic [EXP_W-1:0] exp_set,
   input  logic [IN_W-1:0]  in_mant,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic [EXP_W-1:0] out_exp,
   output logic             out_ovf,
   output logic             out_inexact
);

   // Wide enough for the largest left shift and always reaching past the sign bit.
   localparam int SHW  = IN_W + (1 << EXP_W);
   localparam int WIDE = (SHW > ACC_W) ? SHW : ACC_W + 1;

   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [EXP_W:0]   NEG_LIM = (EXP_W+1)'(IN_W);

   // Returns {saturated, result} for acc +/- mag in ACC_W+1 bits.
   function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                              input logic [ACC_W-1:0] mag,
                                              input logic             sub);
      logic [ACC_W:0] sum;
      if (sub) begin
         sum = {acc[ACC_W-1], acc} - {1'b0, mag};
      end else begin
         sum = {acc[ACC_W-1], acc} + {1'b0, mag};
      end
      if (sum[ACC_W] != sum[ACC_W-1]) begin
         sat_add = {1'b1, (sum[ACC_W] ? ACC_MIN : ACC_MAX)};
      end else begin
         sat_add = {1'b0, sum[ACC_W-1:0]};
      end
   endfunction

   logic signed [EXP_W:0] diff_s;
   logic [EXP_W:0]        neg_s;
   logic [WIDE-1:0]       wide_s;
   logic [IN_W-1:0]       drop_s;
   logic [ACC_W-1:0]      mag_s;
   logic                  ovf_s;
   logic                  inexact_s;

   logic                  s1_valid_r;
   logic [ACC_W-1:0]      s1_mag_r;
   logic                  s1_sign_r;
   logic                  s1_last_r;
   logic [EXP_W-1:0]      s1_exp_r;
   logic                  s1_ovf_r;
   logic                  s1_inexact_r;

   logic [ACC_W-1:0]      acc_r;
   logic                  grp_ovf_r;
   logic                  grp_inexact_r;

   logic                  out_valid_r;
   logic [ACC_W-1:0]      out_acc_r;
   logic [EXP_W-1:0]      out_exp_r;
   logic                  out_ovf_r;
   logic                  out_inexact_r;

   logic                  stall_s;
   logic                  take_s;
   logic                  s2_fire_s;
   logic                  load_s;
   logic [ACC_W:0]        sat_s;
   logic                  fin_ovf_s;
   logic                  fin_inexact_s;

   assign diff_s = $signed({1'b0, in_exp}) - $signed({1'b0, exp_set});

   // Alignment of the incoming mantissa to the reference exponent.
   always_comb begin
      neg_s     = '0;
      wide_s    = '0;
      drop_s    = '0;
      mag_s     = '0;
      ovf_s     = 1'b0;
      inexact_s = 1'b0;
      if (!diff_s[EXP_W]) begin
         wide_s = {{(WIDE-IN_W){1'b0}}, in_mant} << diff_s[EXP_W-1:0];
         if (|wide_s[WIDE-1:ACC_W-1]) begin
            mag_s = ACC_MAX;
            ovf_s = 1'b1;
         end else begin
            mag_s = wide_s[ACC_W-1:0];
         end
      end else begin
         neg_s = -diff_s;
         if (neg_s >= NEG_LIM) begin
            mag_s     = '0;
            inexact_s = |in_mant;
         end else begin
            mag_s     = {{(ACC_W-IN_W){1'b0}}, (in_mant >> neg_s)};
            drop_s    = in_mant & ~({IN_W{1'b1}} << neg_s);
            inexact_s = |drop_s;
         end
      end
   end

   assign stall_s   = s1_valid_r & s1_last_r & out_valid_r & ~out_ready;
   assign in_ready  = ~s1_valid_r | ~stall_s;
   assign take_s    = in_valid & in_ready;
   assign s2_fire_s = s1_valid_r & ~stall_s;
   assign load_s    = s2_fire_s & s1_last_r;

   assign sat_s         = sat_add(acc_r, s1_mag_r, s1_sign_r);
   assign fin_ovf_s     = grp_ovf_r | s1_ovf_r | sat_s[ACC_W];
   assign fin_inexact_s = grp_inexact_r | s1_inexact_r;

   // S1 align register; holds its beat while the output is blocked.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_r   <= 1'b0;
         s1_mag_r     <= '0;
         s1_sign_r    <= 1'b0;
         s1_last_r    <= 1'b0;
         s1_exp_r     <= '0;
         s1_ovf_r     <= 1'b0;
         s1_inexact_r <= 1'b0;
      end else if (clr) begin
         s1_valid_r   <= 1'b0;
         s1_mag_r     <= '0;
         s1_sign_r    <= 1'b0;
         s1_last_r    <= 1'b0;
         s1_exp_r     <= '0;
         s1_ovf_r     <= 1'b0;
         s1_inexact_r <= 1'b0;
      end else if (take_s) begin
         s1_valid_r   <= 1'b1;
         s1_mag_r     <= mag_s;
         s1_sign_r    <= in_sign;
         s1_last_r    <= in_last;
         s1_exp_r     <= exp_set;
         s1_ovf_r     <= ovf_s;
         s1_inexact_r <= inexact_s;
      end else if (!stall_s) begin
         s1_valid_r   <= 1'b0;
      end
   end

   // S2 group accumulator and sticky flags; restart at zero after a last beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r         <= '0;
         grp_ovf_r     <= 1'b0;
         grp_inexact_r <= 1'b0;
      end else if (clr) begin
         acc_r         <= '0;
         grp_ovf_r     <= 1'b0;
         grp_inexact_r <= 1'b0;
      end else if (s2_fire_s) begin
         if (s1_last_r) begin
            acc_r         <= '0;
            grp_ovf_r     <= 1'b0;
            grp_inexact_r <= 1'b0;
         end else begin
            acc_r         <= sat_s[ACC_W-1:0];
            grp_ovf_r     <= fin_ovf_s;
            grp_inexact_r <= fin_inexact_s;
         end
      end
   end

   // Output register; a new result may replace one being consumed this cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_r   <= 1'b0;
         out_acc_r     <= '0;
         out_exp_r     <= '0;
         out_ovf_r     <= 1'b0;
         out_inexact_r <= 1'b0;
      end else if (clr) begin
         out_valid_r   <= 1'b0;
         out_acc_r     <= '0;
         out_exp_r     <= '0;
         out_ovf_r     <= 1'b0;
         out_inexact_r <= 1'b0;
      end else if (load_s) begin
         out_valid_r   <= 1'b1;
         out_acc_r     <= sat_s[ACC_W-1:0];
         out_exp_r     <= s1_exp_r;
         out_ovf_r     <= fin_ovf_s;
         out_inexact_r <= fin_inexact_s;
      end else if (out_ready) begin
         out_valid_r   <= 1'b0;
      end
   end

   assign out_valid   = out_valid_r;
   assign out_acc     = out_acc_r;
   assign out_exp     = out_exp_r;
   assign out_ovf     = out_ovf_r;
   assign out_inexact = out_inexact_r;

endmodule
